// File: rtl/crc32_rx_checker_if.sv
// rtl/crc32_rx_checker_if.sv - byte stream bundle between the PHY side, the CRC-32 receive checker and the frame consumer
//
// in_valid/in_data/in_sop/in_eop   : received byte stream (no backpressure)
// out_valid/out_data/out_sop/out_eop : payload stream with the FCS stripped
// master : the environment side, which drives in_* and observes out_*
// slave  : the checker side, which consumes in_* and drives out_*
interface crc32_rx_checker_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sop;
    logic       in_eop;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;

    modport master (
        output in_valid, in_data, in_sop, in_eop,
        input  out_valid, out_data, out_sop, out_eop
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop,
        output out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/crc32_rx_checker.sv
// rtl/crc32_rx_checker.sv - CRC-32 frame checker that strips the 4-byte FCS and reports per-frame status
//
// clk, rst      : clock and synchronous active-high reset
// bus (slave)   : in_* byte stream in, out_* payload stream out (1-cycle registered latency)
// stat_valid    : one-cycle pulse carrying exactly one of stat_ok/err/runt/abort
// frame_cnt     : frames completed with any outcome, saturating
// err_cnt       : frames ending in err, runt or abort, saturating
module crc32_rx_checker #(
    parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
    parameter logic [31:0] RESIDUE = 32'h0000_0000,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    crc32_rx_checker_if.slave bus,
    output logic             stat_valid,
    output logic             stat_ok,
    output logic             stat_err,
    output logic             stat_runt,
    output logic             stat_abort,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [31:0]      POLY    = 32'h04C1_1DB7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, FRAME} state_t;

    state_t      state;
    logic [31:0] crc_reg;
    logic [7:0]  hold [4];   // hold[0] is the oldest byte
    logic [2:0]  fill;       // bytes in the holdoff buffer, 0..4
    logic [2:0]  len;        // bytes seen in this frame, saturates at 5
    logic        sop_pend;   // next emitted byte is the first payload byte

    logic [31:0] crc_next;
    logic [2:0]  len_next;
    logic        emit;
    logic        emit_eop;
    logic        report;
    logic        nxt_ok;
    logic        nxt_err;
    logic        nxt_runt;
    logic        nxt_abort;

    // MSB-first, non-reflected: in_data[7] enters the register first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[31] ^ d[i]) begin
                r = {r[30:0], 1'b0} ^ POLY;
            end else begin
                r = {r[30:0], 1'b0};
            end
        end
        return r;
    endfunction

    always_comb begin
        crc_next  = crc_step(bus.in_sop ? INIT : crc_reg, bus.in_data);
        len_next  = (len == 3'd5) ? 3'd5 : len + 3'd1;
        emit      = 1'b0;
        emit_eop  = 1'b0;
        report    = 1'b0;
        nxt_ok    = 1'b0;
        nxt_err   = 1'b0;
        nxt_runt  = 1'b0;
        nxt_abort = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_sop) begin
                // An abort wins over a runt when a one-byte frame cuts a
                // frame short, so one pulse never carries two flags.
                if (state == FRAME) begin
                    report    = 1'b1;
                    nxt_abort = 1'b1;
                end else if (bus.in_eop) begin
                    report   = 1'b1;
                    nxt_runt = 1'b1;
                end
            end else if (state == FRAME) begin
                emit = (fill == 3'd4);
                if (bus.in_eop) begin
                    report   = 1'b1;
                    emit_eop = emit;
                    if (len_next == 3'd5) begin
                        nxt_ok  = (crc_next == RESIDUE);
                        nxt_err = (crc_next != RESIDUE);
                    end else begin
                        nxt_runt = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            crc_reg       <= INIT;
            for (int i = 0; i < 4; i++) begin
                hold[i] <= 8'h00;
            end
            fill          <= 3'd0;
            len           <= 3'd0;
            sop_pend      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            stat_valid    <= 1'b0;
            stat_ok       <= 1'b0;
            stat_err      <= 1'b0;
            stat_runt     <= 1'b0;
            stat_abort    <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
        end else begin
            bus.out_valid <= emit;
            bus.out_data  <= emit ? hold[0] : 8'h00;
            bus.out_sop   <= emit & sop_pend;
            bus.out_eop   <= emit_eop;
            stat_valid    <= report;
            stat_ok       <= nxt_ok;
            stat_err      <= nxt_err;
            stat_runt     <= nxt_runt;
            stat_abort    <= nxt_abort;

            if (report && frame_cnt != CNT_MAX) begin
                frame_cnt <= frame_cnt + CNT_ONE;
            end
            if (report && !nxt_ok && err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_ONE;
            end

            if (bus.in_valid) begin
                if (bus.in_sop) begin
                    // Whatever was buffered is dropped; this byte restarts the frame.
                    crc_reg  <= crc_next;
                    hold[0]  <= bus.in_data;
                    len      <= 3'd1;
                    sop_pend <= 1'b1;
                    if (bus.in_eop) begin
                        fill  <= 3'd0;
                        state <= IDLE;
                    end else begin
                        fill  <= 3'd1;
                        state <= FRAME;
                    end
                end else if (state == FRAME) begin
                    crc_reg <= crc_next;
                    len     <= len_next;
                    if (bus.in_eop) begin
                        // The four buffered bytes are the FCS and are discarded.
                        fill  <= 3'd0;
                        state <= IDLE;
                    end else if (fill == 3'd4) begin
                        hold[0]  <= hold[1];
                        hold[1]  <= hold[2];
                        hold[2]  <= hold[3];
                        hold[3]  <= bus.in_data;
                        sop_pend <= 1'b0;
                    end else begin
                        hold[fill[1:0]] <= bus.in_data;
                        fill            <= fill + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_crc32_rx_checker.sv
// tb/tb_crc32_rx_checker.sv - scoreboard bench for crc32_rx_checker with a frame-level reference model
module tb_crc32_rx_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc32_rx_checker_if bus ();

    logic       stat_valid, stat_ok, stat_err, stat_runt, stat_abort;
    logic [3:0] frame_cnt, err_cnt;

    crc32_rx_checker #(
        .INIT    (32'hFFFF_FFFF),
        .RESIDUE (32'h0000_0000),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .stat_valid (stat_valid),
        .stat_ok    (stat_ok),
        .stat_err   (stat_err),
        .stat_runt  (stat_runt),
        .stat_abort (stat_abort),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        int         cyc;
    } out_t;
    typedef struct {
        logic [3:0] flags;   // {ok, err, runt, abort}
        int         cyc;
    } st_t;

    localparam logic [3:0] F_OK    = 4'b1000;
    localparam logic [3:0] F_ERR   = 4'b0100;
    localparam logic [3:0] F_RUNT  = 4'b0010;
    localparam logic [3:0] F_ABORT = 4'b0001;

    out_t exp_out[$];
    st_t  exp_st[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    bq_t  cur;
    bit   in_frame = 1'b0;
    int   m_frames = 0;
    int   m_errs   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // CRC-32 of a whole byte sequence: init all-ones, MSB-first, no final XOR.
    function automatic logic [31:0] crc_of(input bq_t q);
        logic [31:0] r;
        r = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                r = {r[30:0], 1'b0} ^ (((r[31] ^ q[i][b]) != 1'b0) ? 32'h04C1_1DB7 : 32'h0);
            end
        end
        return r;
    endfunction

    function automatic bq_t good_frame();
        bq_t g;
        g = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h03, 8'h76, 8'hE6, 8'hE7};
        return g;
    endfunction

    task automatic push_stat(input logic [3:0] f, input int c);
        exp_st.push_back('{f, c});
        if (m_frames < 15) m_frames++;
        if (f != F_OK && m_errs < 15) m_errs++;
    endtask

    // Frame-level model: a frame's byte k (k >= 4) releases byte k-4 as payload;
    // the last four bytes are never released.
    task automatic drive_byte(input logic [7:0] b, input bit sop, input bit eop);
        int c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_sop   = sop;
        bus.in_eop   = eop;
        c = cyc + 1;
        if (sop) begin
            if (in_frame) push_stat(F_ABORT, c);
            cur.delete();
            cur.push_back(b);
            in_frame = 1'b1;
            if (eop) begin
                if (!(c > 0 && exp_st.size() > 0 && exp_st[exp_st.size()-1].cyc == c)) push_stat(F_RUNT, c);
                in_frame = 1'b0;
            end
        end else if (in_frame) begin
            cur.push_back(b);
            if (cur.size() >= 5) exp_out.push_back('{cur[cur.size()-5], cur.size() == 5, eop, c});
            if (eop) begin
                if (cur.size() >= 5) push_stat((crc_of(cur) == 32'h0) ? F_OK : F_ERR, c);
                else push_stat(F_RUNT, c);
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            bus.in_sop   = 1'($urandom);
            bus.in_eop   = 1'($urandom);
        end
    endtask

    task automatic send_frame(input bq_t f, input bit with_eop, input int gap_pct);
        foreach (f[i]) begin
            if (i > 0 && $urandom_range(99) < gap_pct) idle($urandom_range(1, 3));
            drive_byte(f[i], i == 0, with_eop && (i == f.size() - 1));
        end
    endtask

    task automatic drain_and_check(input string name);
        int n;
        idle(1);
        n = 0;
        while ((exp_out.size() != 0 || exp_st.size() != 0) && n < 40) begin
            idle(1);
            n++;
        end
        idle(2);
        check({name, "_drained"}, 64'(exp_out.size() + exp_st.size()), 64'd0);
        check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(m_frames));
        check({name, "_err_cnt"}, 64'(err_cnt), 64'(m_errs));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a byte or a status.
    out_t eo;
    st_t  es;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_out.size() == 0) begin
                    check("out_unexpected", {bus.out_data, bus.out_sop, bus.out_eop}, 64'h0);
                end else begin
                    eo = exp_out.pop_front();
                    check("out_beat", {bus.out_data, bus.out_sop, bus.out_eop}, {eo.data, eo.sop, eo.eop});
                    check("out_cycle", 64'(cyc), 64'(eo.cyc));
                end
            end
            if (stat_valid) begin
                if (exp_st.size() == 0) begin
                    check("stat_unexpected", {stat_ok, stat_err, stat_runt, stat_abort}, 64'h0);
                end else begin
                    es = exp_st.pop_front();
                    check("stat_flags", {stat_ok, stat_err, stat_runt, stat_abort}, es.flags);
                    check("stat_cycle", 64'(cyc), 64'(es.cyc));
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, stat_valid, stat_ok,
                     stat_err, stat_runt, stat_abort, frame_cnt, err_cnt}, 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f, p;
        logic [31:0] fcs;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Known-answer good frame, back to back.
        send_frame(good_frame(), 1'b1, 0);
        drain_and_check("good");

        // Corrupted last FCS byte.
        f = good_frame();
        f[12] = 8'hE6;
        send_frame(f, 1'b1, 0);
        drain_and_check("corrupt");

        // Stray bytes in IDLE, then a one-byte runt and a four-byte runt.
        drive_byte(8'h55, 1'b0, 1'b1);
        drive_byte(8'hAA, 1'b0, 1'b0);
        drive_byte(8'h42, 1'b1, 1'b1);
        f = '{8'h03, 8'h76, 8'hE6, 8'hE7};
        send_frame(f, 1'b1, 0);
        drain_and_check("runt");

        // Good frame with random idle gaps.
        send_frame(good_frame(), 1'b1, 50);
        drain_and_check("gaps");

        // Six bytes of frame A, then frame B restarts the stream.
        f.delete();
        repeat (6) f.push_back(8'($urandom));
        send_frame(f, 1'b0, 0);
        send_frame(good_frame(), 1'b1, 0);
        drain_and_check("abort");

        // Random frames with valid or single-bit-corrupted FCS.
        for (int n = 0; n < 8; n++) begin
            p.delete();
            repeat ($urandom_range(1, 12)) p.push_back(8'($urandom));
            fcs = crc_of(p);
            f = p;
            f.push_back(fcs[31:24]);
            f.push_back(fcs[23:16]);
            f.push_back(fcs[15:8]);
            f.push_back(fcs[7:0]);
            if ($urandom_range(1) == 1) begin
                int k;
                k = $urandom_range(f.size() - 1);
                f[k] = f[k] ^ (8'h01 << $urandom_range(7));
            end
            send_frame(f, 1'b1, 30);
            idle($urandom_range(0, 2));
        end
        drain_and_check("random");

        // Reset in the middle of a frame drops it without status.
        f = good_frame();
        f = f[0:6];
        send_frame(f, 1'b0, 0);
        idle(2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_frame = 1'b0;
        m_frames = 0;
        m_errs   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_mid_frame");
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(good_frame(), 1'b1, 0);
        drain_and_check("after_reset");

        // Counter saturation with 4-bit counters.
        f = good_frame();
        f[12] = 8'hE6;
        repeat (17) send_frame(f, 1'b1, 0);
        drain_and_check("saturate");
        check("sat_frame_cnt_15", 64'(frame_cnt), 64'd15);
        check("sat_err_cnt_15", 64'(err_cnt), 64'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crc32_rx_checker.md
Name: crc32_rx_checker

Overview:
- Receive-side companion to the team's byte-wise CRC-32 generator.
- Accepts a byte stream framed by SOP/EOP in which each frame ends with a 4-byte FCS, and checks the CRC over the whole frame.
- Strips the FCS through a 4-byte holdoff buffer, forwards the payload, and reports per-frame status plus saturating statistics.
- Sits between the byte-level PHY/deserialiser and the frame consumer.

Parameters:
- INIT, 32'hFFFF_FFFF, CRC register value loaded on each SOP.
- RESIDUE, 32'h0000_0000, register value that marks a good frame after all bytes, FCS included, have been accumulated.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input byte strobe; the block applies no backpressure
- in_data  in  8  input byte
- in_sop  in  1  first byte of frame, qualified by in_valid
- in_eop  in  1  last byte of frame, qualified by in_valid
- out_valid  out  1  payload byte strobe
- out_data  out  8  payload byte
- out_sop  out  1  first payload byte
- out_eop  out  1  last payload byte
- stat_valid  out  1  one-cycle pulse when a frame's status is reported
- stat_ok  out  1  CRC matched and frame length >= 5
- stat_err  out  1  CRC mismatch, frame length >= 5
- stat_runt  out  1  frame shorter than 5 bytes
- stat_abort  out  1  frame cut short by a new SOP before its EOP
- frame_cnt  out  CNT_W  frames completed (any outcome), saturating
- err_cnt  out  CNT_W  frames with err, runt or abort, saturating

Behaviour:
- Reset: every output and counter is 0, the holdoff buffer is emptied, the state is IDLE, and the CRC register is loaded with INIT.
- CRC step: polynomial 0x04C11DB7, non-reflected, MSB-first, so in_data[7] is the first bit shifted in.
  - Per valid byte, crc_next = step(crc_reg, in_data).
  - On SOP the step starts from INIT, not from crc_reg.
  - FCS is transmitted most-significant byte first; no output XOR is applied.
- States:
  - IDLE: bytes without in_sop are dropped silently, including a stray in_eop. A byte with in_sop goes to FRAME (or is handled directly if in_eop is also set).
  - FRAME: accumulates bytes. A byte with in_eop reports status and returns to IDLE.
- Holdoff buffer: 4 bytes deep; a byte count tracks fill and saturates at 4.
  - When a valid byte arrives and the buffer already holds 4, the oldest byte is emitted next cycle with out_valid=1 and the new byte is shifted in.
  - out_sop is set on the first byte emitted for the frame.
  - On the in_eop beat the oldest byte is emitted with out_eop=1. The 4 remaining bytes (the FCS) are discarded and the buffer is cleared.
  - Output latency is exactly 1 cycle after the triggering input beat. All outputs are registered.
- Status: stat_valid pulses 1 cycle after the in_eop beat, in the same cycle as out_eop when one exists. Exactly one of the four flags is set per pulse.
  - Length >= 5: stat_ok = (crc_next == RESIDUE), and stat_err is its complement.
  - Length <= 4, including in_sop and in_eop on the same beat: stat_runt. No out_* bytes are emitted for that frame.
- in_sop while in FRAME:
  - The current frame is aborted: stat_valid=1 and stat_abort=1 one cycle later.
  - If payload was already emitted, the last emitted byte is not re-flagged. out_eop is not generated, and the consumer must treat stat_abort as the frame terminator.
  - The buffer is cleared, the new byte starts a new frame with CRC from INIT, and the state stays FRAME.
- Counters: frame_cnt increments on every stat_valid. err_cnt increments when stat_valid coincides with err, runt or abort. Both hold at 2^CNT_W-1.
- Reset mid-frame: the frame is dropped without a status pulse, and counters return to 0.
- in_valid=0 gaps inside a frame are allowed and leave all state unchanged.

Test Plan:
- Good frame: 0x31..0x39 ("123456789") then 0x03,0x76,0xE6,0xE7, back-to-back -> 9 out bytes 0x31..0x39 with out_sop on 0x31 and out_eop on 0x39; stat_ok=1 the same cycle; frame_cnt=1, err_cnt=0.
- Corrupt frame: same frame with the last FCS byte 0xE6 -> 9 payload bytes still forwarded; stat_err=1; err_cnt=1.
- Runts: 1-byte frame (sop+eop together), then a 4-byte frame 0x03,0x76,0xE6,0xE7 -> no out_valid; two stat_runt pulses; frame_cnt=2, err_cnt=2.
- Gaps: good frame from the first test with random in_valid=0 gaps -> identical out_data sequence; stat_ok=1; each output 1 cycle after its trigger beat.
- Abort: 6 bytes of frame A, then in_sop of the good frame from the first test -> stat_abort pulse 1 cycle after the new SOP; frame B is forwarded intact with stat_ok; frame_cnt=2, err_cnt=1.
- Reset and saturation: assert rst mid-frame -> all outputs 0 and no stat pulse; then with CNT_W=4, send 17 corrupt frames -> err_cnt and frame_cnt hold at 15.
